sqrt_fixed_point_square: RTL and testbench

- Inverse of the fixed-point square-root unit: reconstructs the radicand from a (root, rem) pair as rad = (root*root + rem) >> FBITS.
- Used as a self-check and round-trip partner for the sqrt datapath.
- Uses the same start/busy/valid handshake and Q(WIDTH-FBITS).FBITS format as the sqrt unit.
- Iterative shift-add multiplier: one multiplier bit per clock, no hardware multiplier.

---
 rtl/sqrt_fixed_point_square.sv | 109 ++++++++++
 tb/tb_sqrt_fixed_point_square.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sqrt_fixed_point_square.sv
// Iterative shift-add squarer: rebuilds a fixed-point radicand from a sqrt (root, rem) pair.
// Computes rad = (root*root + rem) >> FBITS using one multiplier bit per clock.
module sqrt_fixed_point_square #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] root,
  input  logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] rad,
  output logic             exact,
  output logic             ovf
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    acc_sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, valid_d, exact_d, ovf_d;
  logic [WIDTH-1:0] rad_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      rad      <= '0;
      exact    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      valid    <= valid_d;
      rad      <= rad_d;
      exact    <= exact_d;
      ovf      <= ovf_d;
    end
  end

  // Multiplier is shifted right and multiplicand left, so bit 0 always selects the current addend
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state, datapath and result logic
  always_comb begin
    state_d  = state_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    valid_d  = 1'b0;
    rad_d    = rad;
    exact_d  = exact;
    ovf_d    = ovf;
    case (state_q)
      IDLE: begin
        if (start) begin
          mplier_d = root;
          mcand_d  = AW'(root);
          acc_d    = AW'(rem);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
          exact_d = (acc_sum[FBITS-1:0] == '0);
          if (|acc_sum[AW-1:WIDTH+FBITS]) begin
            ovf_d = 1'b1;
            rad_d = '1;
          end else begin
            ovf_d = 1'b0;
            rad_d = acc_sum[WIDTH+FBITS-1:FBITS];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sqrt_fixed_point_square.sv
// Scoreboard bench for sqrt_fixed_point_square: stimulus pushes model results, a monitor pops on valid.
module tb_sqrt_fixed_point_square;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned FBITS = 8;

  typedef struct {
    logic [WIDTH-1:0] rad;
    logic             exact;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] root = '0;
  logic [WIDTH-1:0] rem = '0;
  logic             busy, valid, exact, ovf;
  logic [WIDTH-1:0] rad;

  int   tests = 0;
  int   fails = 0;
  int   vcount = 0;
  exp_t sb[$];

  sqrt_fixed_point_square #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .root(root), .rem(rem),
    .busy(busy), .valid(valid), .rad(rad), .exact(exact), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width square
  function automatic exp_t model(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
    logic [63:0] full, q;
    exp_t e;
    full    = 64'(r) * 64'(r) + 64'(m);
    q       = full / (64'd1 << FBITS);
    e.exact = ((full % (64'd1 << FBITS)) == 64'd0);
    e.ovf   = (q >= (64'd1 << WIDTH));
    e.rad   = e.ovf ? {WIDTH{1'b1}} : WIDTH'(q);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      exp_t e;
      vcount++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rad", 64'(rad), 64'(e.rad));
        chk("exact", 64'(exact), 64'(e.exact));
        chk("ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  // Caller is at a negedge; start is sampled on the next posedge
  task automatic issue(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m, input bit expect_result);
    root  = r;
    rem   = m;
    start = 1'b1;
    if (expect_result) sb.push_back(model(r, m));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
    int c;
    @(negedge clk);
    issue(r, m, 1'b1);
    wait_done(c);
  endtask

  initial begin
    int c, v0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_rad", 64'(rad), 64'd0);
    chk("rst_exact", 64'(exact), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and busy duration
    issue(16'h0F40, 16'd0, 1'b1);
    wait_done(c);
    chk("busy_cycles", 64'(c), 64'(WIDTH));
    chk("valid_at_latency", 64'(valid), 64'd1);
    chk("rad_0f40", 64'(rad), 64'hE890);
    @(negedge clk);
    chk("valid_one_cycle", 64'(valid), 64'd0);

    run(16'd128, 16'd0);
    run(16'd362, 16'd28);
    run(16'd362, 16'd0);
    run(16'hFFFF, 16'hFFFF);
    run(16'd1, 16'd0);
    run(16'd0, 16'hABCD);

    // Starts during a calculation must be ignored
    @(negedge clk);
    v0 = vcount;
    issue(16'd300, 16'd7, 1'b1);
    repeat (2) @(negedge clk);
    issue(16'hF00F, 16'h1234, 1'b0);
    repeat (6) @(negedge clk);
    issue(16'h8001, 16'hFFFF, 1'b0);
    wait_done(c);
    repeat (3) @(negedge clk);
    chk("ignored_start_pulses", 64'(vcount - v0), 64'd1);

    // Asynchronous reset mid-calculation
    issue(16'h1234, 16'd5, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_rad", 64'(rad), 64'd0);
    chk("abort_exact", 64'(exact), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (25) @(negedge clk);
    chk("abort_no_valid", 64'(vcount - v0), 64'd0);
    run(16'h1234, 16'd5);

    // Start accepted during the valid cycle
    @(negedge clk);
    issue(16'd1000, 16'd3, 1'b1);
    wait_done(c);
    issue(16'd2000, 16'd77, 1'b1);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(c);

    // Random operations, sometimes back-to-back
    for (int i = 0; i < 60; i++) begin
      logic [WIDTH-1:0] r, m;
      r = WIDTH'($urandom);
      m = WIDTH'($urandom);
      if (i % 4 == 0) r = WIDTH'($urandom_range(0, 255));
      if (i % 5 == 0) m = '0;
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(r, m, 1'b1);
      wait_done(c);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
